// File: rtl/display_pkg.sv
// Shared constants and types for the hex display scanner and other debug tops.
//   SEG_TABLE : nibble -> segment pattern, {g,f,e,d,c,b,a}, active-high
//   SEG_OFF   : active-low cathode value with every segment dark
//   phase_e   : per-slot scan phase
package display_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } phase_e;

endpackage

// File: rtl/hex_display_scanner_if.sv
// Capture/display bus of the hex display scanner.
//   value_in   : 16-bit value to show, nibble i on digit i (digit 0 rightmost)
//   load       : capture strobe for value_in/dp_in
//   dp_in      : decimal-point request per digit, 1 = lit
//   blank_all  : forces every anode off while high
//   seg_n      : segment cathodes, active-low, {g,f,e,d,c,b,a}
//   dp_n       : decimal-point cathode, active-low
//   an_n       : digit anodes, active-low
//   frame_tick : one-cycle pulse per frame boundary
interface hex_display_scanner_if;
    logic [15:0] value_in;
    logic        load;
    logic [3:0]  dp_in;
    logic        blank_all;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_tick;

    modport master (
        output value_in, load, dp_in, blank_all,
        input  seg_n, dp_n, an_n, frame_tick
    );

    modport slave (
        input  value_in, load, dp_in, blank_all,
        output seg_n, dp_n, an_n, frame_tick
    );
endinterface

// File: rtl/hex_display_scanner_hex_to_7seg.sv
// Combinational nibble to 7-segment pattern lookup.
//   nibble_i  : hex digit 0..F
//   pattern_o : {g,f,e,d,c,b,a}, active-high
module hex_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] pattern_o
);
    assign pattern_o = SEG_TABLE[nibble_i];
endmodule

// File: rtl/hex_display_scanner.sv
// Four-digit multiplexed common-anode hex display driver with frame-synchronous
// updates, inter-digit blanking, leading-zero blanking and per-digit points.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : slave side of hex_display_scanner_if (capture inputs, pin outputs)
//
// state | meaning
// BLANK | first BLANK_CYCLES of a slot, all anodes off to kill ghosting
// ON    | rest of the slot, current digit driven
module hex_display_scanner
    import display_pkg::*;
#(
    parameter int DIGIT_CYCLES = 6250,
    parameter int BLANK_CYCLES = 250,
    parameter bit LZB_EN       = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    hex_display_scanner_if.slave  bus
);
    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ON   = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    digit_q, digit_d;
    phase_e        phase_q, phase_d;
    logic [19:0]   pend_q, pend_d;     // {value, dp}
    logic [19:0]   disp_q, disp_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;
    logic          tick_q, tick_d;

    logic          frame_end;
    logic [15:0]   disp_val;
    logic [3:0]    disp_dp;
    logic [3:0]    cur_nib;
    logic [6:0]    cur_pat;
    logic          lz_blank;

    assign disp_val = disp_q[19:4];
    assign disp_dp  = disp_q[3:0];
    assign cur_nib  = disp_val[{digit_q, 2'b00} +: 4];

    hex_to_7seg u_hex_to_7seg (
        .nibble_i  (cur_nib),
        .pattern_o (cur_pat)
    );

    // Digit d>0 is dark when it and every more-significant nibble are zero.
    assign lz_blank = LZB_EN && (digit_q != 2'd0) &&
                      ((disp_val >> {digit_q, 2'b00}) == 16'h0000);

    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        digit_d   = digit_q;
        phase_d   = phase_q;
        frame_end = 1'b0;
        if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            digit_d   = digit_q + 2'd1;
            phase_d   = BLANK;
            frame_end = (digit_q == 2'd3);
        end else if (cnt_d == CNT_ON) begin
            phase_d   = ON;
        end

        pend_d = bus.load ? {bus.value_in, bus.dp_in} : pend_q;
        // pend_d already carries a same-edge load, so it wins over the old pending.
        disp_d = frame_end ? pend_d : disp_q;

        an_d   = 4'hF;
        seg_d  = SEG_OFF;
        dp_d   = 1'b1;
        tick_d = frame_end;
        if (phase_q == ON && !bus.blank_all && !lz_blank) begin
            an_d  = ~(4'b0001 << digit_q);
            seg_d = ~cur_pat;
            dp_d  = ~disp_dp[digit_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            digit_q <= 2'd0;
            phase_q <= BLANK;
            pend_q  <= '0;
            disp_q  <= '0;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
            an_q    <= 4'hF;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            phase_q <= phase_d;
            pend_q  <= pend_d;
            disp_q  <= disp_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            tick_q  <= tick_d;
        end
    end

    assign bus.seg_n      = seg_q;
    assign bus.dp_n       = dp_q;
    assign bus.an_n       = an_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
- Downstream consumer of the CPU debug address bus.
- Latches a 16-bit value, e.g. the CPU address, on a strobe such as the delayed CPU clock enable.
- Drives a 4-digit multiplexed common-anode 7-segment display, showing the full address in hex instead of a single nibble.
- Provides tear-free frame-synchronous updates, inter-digit ghost blanking, leading-zero blanking and per-digit decimal points.

Parameters:
- DIGIT_CYCLES, 6250: clk cycles per digit slot; 4 kHz digit rate and 1 kHz frame at 25 MHz.
- BLANK_CYCLES, 250: cycles at the start of each slot with all anodes off. Legal range is 1 <= BLANK_CYCLES < DIGIT_CYCLES.
- LZB_EN, 1: 1 enables leading-zero blanking.

Ports:
- clk  in  1  system clock, 25 MHz.
- rst  in  1  synchronous, active-high reset.
- value_in  in  16  value to display; nibble i is shown on digit i, and digit 0 is the rightmost.
- load  in  1  capture strobe; value_in and dp_in are sampled on each clk edge where load=1.
- dp_in  in  4  decimal-point request per digit, 1 = lit.
- blank_all  in  1  forces all anodes off while high.
- seg_n  out  7  segment cathodes, active-low, ordered {g,f,e,d,c,b,a}.
- dp_n  out  1  decimal-point cathode, active-low.
- an_n  out  4  digit anode selects, active-low, one-hot-low when lit.
- frame_tick  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset: seg_n=7'h7F, dp_n=1, an_n=4'hF, frame_tick=0. All internal registers clear: pending value/dp, display value/dp, slot counter, digit index. Phase=BLANK, digit=0. A reset asserted mid-frame aborts the frame immediately; the next cycle after release starts BLANK of digit 0.
- Capture: load=1 writes pending <= {value_in, dp_in}. Multiple loads within a frame leave only the last one effective. No handshake; load is never back-pressured.
- Display register: loads from pending only at a frame boundary, so there is no mid-frame tearing.
- Scan FSM, per digit slot of DIGIT_CYCLES cycles:
  - BLANK for BLANK_CYCLES cycles, then ON for DIGIT_CYCLES-BLANK_CYCLES cycles.
  - Digit order is 0,1,2,3, then wraps to 0.
  - The slot counter runs 0..DIGIT_CYCLES-1; the BLANK->ON transition occurs when the counter reaches BLANK_CYCLES.
- Frame boundary:
  - Occurs on the last cycle of digit 3 ON; the next cycle is digit 0 BLANK.
  - On that cycle: display <= pending and frame_tick pulses high for exactly 1 cycle.
  - A load on that same edge still wins: pending is bypassed, so display gets value_in.
- Outputs: all registered, with 1 cycle latency from FSM state to pins.
  - BLANK phase: an_n=4'hF, seg_n=7'h7F, dp_n=1.
  - ON phase: an_n has bit d low; seg_n = ~pattern(display nibble d); dp_n = ~display_dp[d].
- Leading-zero blanking: when LZB_EN=1, digit d>0 whose nibbles d..3 are all zero is blanked during ON (an_n=4'hF). Digit 0 is never blanked, so value 0 shows "0". Decimal points are suppressed on blanked digits.
- blank_all: forces an_n=4'hF, seg_n=7'h7F, dp_n=1. The scan counter and frame_tick keep running, and display updates still occur.
- Frame length is exactly 4*DIGIT_CYCLES cycles. The counter is sized ceil(log2(DIGIT_CYCLES)) bits and never wraps except at slot end.

Decomposition:
- Package display_pkg:
  - 16-entry segment pattern constant table, GFEDCBA active-high. 0=7'h3F, 1=7'h06, 2=7'h5B, 3=7'h4F, 4=7'h66, 5=7'h6D, 6=7'h7D, 7=7'h07, 8=7'h7F, 9=7'h6F, A=7'h77, b=7'h7C, C=7'h39, d=7'h5E, E=7'h79, F=7'h71.
  - Phase enum: BLANK, ON.
  - SEG_OFF constant = 7'h7F.
- Sub-module hex_to_7seg: combinational nibble-to-pattern lookup, shared with other debug tops.

Test Plan (DIGIT_CYCLES=8, BLANK_CYCLES=2 unless noted):
- Reset, then idle 40 cycles -> every 8-cycle slot shows an_n=F for 2 cycles, then digit 0 lit with seg_n=~7'h3F for 6 cycles; digits 1-3 stay blanked by LZB; frame_tick pulses every 32 cycles.
- load value_in=16'hE00A, dp_in=4'b0001 mid-frame -> current frame unchanged. After the next frame_tick, digits 0..3 show A,0,0,E (seg_n ~77,~3F,~3F,~79), and dp_n=0 on digit 0 only.
- Two loads in one frame, 16'h1234 then 16'hBEEF -> the next frame shows only BEEF; 1234 never appears on any digit.
- LZB_EN=1, value 16'h0040 -> digit 1 shows 4 and digits 2-3 stay an_n=F. With LZB_EN=0 -> digits 3,2,0 show 0.
- Hold blank_all=1 for 2 frames -> an_n=F throughout and frame_tick continues every 32 cycles. On release, the display resumes at the correct slot.
- rst pulsed during digit 2 ON -> the cycle after reset shows all outputs at reset values. After release, digit 0 BLANK begins, display=0, and the first frame_tick arrives 32 cycles later.
